// File: rtl/reg_file_2r1w.sv
// Integer register file: two combinational read ports, one synchronous write port.
// x0 reads as zero; x2 resets to SP_INIT. Define RF_BYPASS_EN for write-first reads.
module reg_file_2r1w #(
  parameter int                 WIDTH   = 32,
  parameter int                 DEPTH   = 32,
  parameter int                 ADDR_W  = 5,
  parameter logic [WIDTH-1:0]   SP_INIT = 'h0000_0FFC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [WIDTH-1:0]  rs1_data,
  output logic [WIDTH-1:0]  rs2_data
);

  if (2**ADDR_W != DEPTH) begin : g_bad_cfg
    $error("reg_file_2r1w: DEPTH must equal 2**ADDR_W");
  end

  logic [WIDTH-1:0] regs [DEPTH];

  // NOTE: the array has a reset value, so it must remain discrete flops; a RAM macro cannot be cleared in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: non-blocking assignment keeps every flop updating from pre-edge values.
        regs[i] <= (i == 2) ? SP_INIT : '0;
      end
    end else if (we && rd_addr != '0) begin
      regs[rd_addr] <= rd_data;
    end
  end

  // NOTE: each output is assigned a default first so no path through the block can infer a latch.
  always_comb begin
    rs1_data = regs[rs1_addr];
`ifdef RF_BYPASS_EN
    if (we && !rst && rd_addr != '0 && rs1_addr == rd_addr) rs1_data = rd_data;
`endif
    if (rs1_addr == '0) rs1_data = '0;
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
`ifdef RF_BYPASS_EN
    if (we && !rst && rd_addr != '0 && rs2_addr == rd_addr) rs2_data = rd_data;
`endif
    if (rs2_addr == '0) rs2_data = '0;
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: directed vector table plus hand-written
// sequences for reset priority, read-during-write and ALU-source mux integration.
module tb_reg_file_2r1w;

  localparam logic [31:0] SP = 32'h0000_0FFC;
`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  rd_addr, rs1_addr, rs2_addr;
  logic [31:0] rd_data, rs1_data, rs2_data;

  // ALU-source mux: input A = rs2_data, input B = immediate
  logic        sel;
  logic [31:0] imm;
  logic [31:0] mux_out;
  assign mux_out = sel ? imm : rs2_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_2r1w dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Expected reads are sampled before the edge that performs the row's write.
    vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd0,  5'd2,  32'h0,          SP};
    vecs[1] = '{1'b0, 5'd5,  32'h0,         5'd5,  5'd5,  32'hDEAD_BEEF,  32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd5,  5'd0,  32'hDEAD_BEEF,  32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,          32'h0};
    vecs[4] = '{1'b1, 5'd31, 32'h8000_0001, 5'd2,  5'd5,  SP,             32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 5'd2,  32'h0000_1234, 5'd31, 5'd1,  32'h8000_0001,  32'h0};
    vecs[6] = '{1'b0, 5'd2,  32'h0000_5555, 5'd2,  5'd31, 32'h0000_1234,  32'h8000_0001};
    vecs[7] = '{1'b0, 5'd0,  32'h0,         5'd2,  5'd2,  32'h0000_1234,  32'h0000_1234};
    vecs[8] = '{1'b1, 5'd5,  32'h0,         5'd0,  5'd1,  32'h0,          32'h0};
    vecs[9] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'h0,          32'h0};

    rst = 1'b1; we = 1'b0; rd_addr = '0; rd_data = '0;
    rs1_addr = '0; rs2_addr = '0; sel = 1'b0; imm = 32'h4;

    after_edge();
    after_edge();
    rst = 1'b0;

    // Reset sweep on both ports
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      @(negedge clk);
      check($sformatf("reset_rs1[%0d]", i), rs1_data, (i == 2) ? SP : 32'h0);
      check($sformatf("reset_rs2[%0d]", 31 - i), rs2_data, (31 - i == 2) ? SP : 32'h0);
    end
    after_edge();

    // Directed vector table
    for (int v = 0; v < 10; v++) begin
      we = vecs[v].we; rd_addr = vecs[v].rd; rd_data = vecs[v].wdata;
      rs1_addr = vecs[v].a1; rs2_addr = vecs[v].a2;
      @(negedge clk);
      check($sformatf("vec%0d_rs1", v), rs1_data, vecs[v].e1);
      check($sformatf("vec%0d_rs2", v), rs2_data, vecs[v].e2);
      after_edge();
    end
    we = 1'b0;

    // Reset asserted mid-cycle has no effect before the edge
    we = 1'b1; rd_addr = 5'd4; rd_data = 32'hAA;
    after_edge();
    we = 1'b0; rst = 1'b1; rs1_addr = 5'd4;
    @(negedge clk);
    check("rst_async_ignored", rs1_data, 32'hAA);

    // Reset priority over a simultaneous write
    we = 1'b1; rd_addr = 5'd7; rd_data = 32'h1234_5678;
    after_edge();
    rst = 1'b0; we = 1'b0; rs1_addr = 5'd2; rs2_addr = 5'd7;
    @(negedge clk);
    check("rst_prio_x7", rs2_data, 32'h0);
    check("rst_sp_restored", rs1_data, SP);
    rs1_addr = 5'd4;
    @(negedge clk);
    check("rst_cleared_x4", rs1_data, 32'h0);

    // Writes resume on the first edge with rst low
    we = 1'b1; rd_addr = 5'd7; rd_data = 32'h77;
    after_edge();
    we = 1'b0;
    @(negedge clk);
    check("write_after_rst", rs2_data, 32'h77);

    // Read-during-write on the same register
    we = 1'b1; rd_addr = 5'd9; rd_data = 32'h11;
    after_edge();
    we = 1'b1; rd_addr = 5'd9; rd_data = 32'h22; rs1_addr = 5'd9; rs2_addr = 5'd0;
    @(negedge clk);
    check("rdw_before_edge", rs1_data, BYPASS ? 32'h22 : 32'h11);
    check("rdw_x0_zero", rs2_data, 32'h0);
    after_edge();
    we = 1'b0;
    @(negedge clk);
    check("rdw_after_edge", rs1_data, 32'h22);

    // ALU-source mux integration
    we = 1'b1; rd_addr = 5'd3; rd_data = 32'hA5;
    after_edge();
    we = 1'b0; rs2_addr = 5'd3; imm = 32'h4; sel = 1'b0;
    @(negedge clk);
    check("mux_sel0", mux_out, 32'hA5);
    sel = 1'b1;
    @(negedge clk);
    check("mux_sel1", mux_out, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
